// File: rtl/awg_seq_ctrl.sv
// awg_seq_ctrl: step sequencer for the signal generator controls.
// A table of steps (waveform, frequency, amplitude, phase, dwell, last) is
// written while idle; on start the steps are played in order, each held for
// its dwell count, then the block either stops (done pulse) or wraps to 0.
// Optional frequency sweep within a step: define AWG_SEQ_SWEEP_EN.
//
// Handshake: single-cycle strobes, no backpressure. wr_en is accepted only in
// IDLE (otherwise wr_err pulses on the next cycle). start is accepted only in
// IDLE without stop. stop forces IDLE from RUN or DONE on the next cycle.
`timescale 1ns/1ps
module awg_seq_ctrl #(
  parameter int DEPTH   = 8,
  parameter int DWELL_W = 24,
`ifdef AWG_SEQ_SWEEP_EN
  parameter int SWEEP_DIV = 1024,
`endif
  localparam int AW = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  logic [2:0]         wr_wave,
  input  logic [11:0]        wr_freq,
  input  logic [2:0]         wr_amp,
  input  logic [7:0]         wr_phase,
  input  logic [DWELL_W-1:0] wr_dwell,
  input  logic               wr_last,
`ifdef AWG_SEQ_SWEEP_EN
  input  logic [7:0]         wr_finc,
`endif
  input  logic               start,
  input  logic               stop,
  input  logic               loop,
  output logic               wr_err,
  output logic               busy,
  output logic               done,
  output logic               step_strobe,
  output logic [AW-1:0]      step_idx,
  output logic [2:0]         state,
  output logic [11:0]        state_freq,
  output logic [2:0]         state_amp,
  output logic [7:0]         state_phase
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

  state_t state_q, state_d;

  // step table
  logic [2:0]         t_wave  [DEPTH];
  logic [11:0]        t_freq  [DEPTH];
  logic [2:0]         t_amp   [DEPTH];
  logic [7:0]         t_phase [DEPTH];
  logic [DWELL_W-1:0] t_dwell [DEPTH];
  logic               t_last  [DEPTH];

  logic               loop_q;
  logic [DWELL_W-1:0] cnt_q;

  logic               wr_accept;
  logic               load;
  logic [AW-1:0]      load_idx;
  logic               go_off;
  logic               done_d;

  logic               bypass;
  logic [2:0]         f_wave;
  logic [11:0]        f_freq;
  logic [2:0]         f_amp;
  logic [7:0]         f_phase;
  logic [DWELL_W-1:0] f_dwell;

`ifdef AWG_SEQ_SWEEP_EN
  localparam int SC_W = (SWEEP_DIV > 1) ? $clog2(SWEEP_DIV) : 1;
  // The entry cycle already counts as the first cycle of the first interval.
  localparam logic [SC_W-1:0] SC_INIT = (SWEEP_DIV > 1) ? SC_W'(1) : SC_W'(0);
  logic [7:0]      t_finc [DEPTH];
  logic [7:0]      f_finc;
  logic [7:0]      finc_q;
  logic [SC_W-1:0] sc_q;
  logic [12:0]     fsum;
  assign fsum = {1'b0, state_freq} + {5'b0, finc_q};
`endif

  assign wr_accept = wr_en && (state_q == S_IDLE);

  // Next-state and step-sequencing decisions.
  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    load_idx = '0;
    go_off   = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          state_d = S_RUN;
          load    = 1'b1;
        end
      end
      S_RUN: begin
        if (stop) begin
          state_d = S_IDLE;
          go_off  = 1'b1;
        end else if (cnt_q == '0) begin
          if (!t_last[step_idx] && (step_idx != AW'(DEPTH - 1))) begin
            load     = 1'b1;
            load_idx = step_idx + AW'(1);
          end else if (loop_q) begin
            load = 1'b1;
          end else begin
            state_d = S_DONE;
            go_off  = 1'b1;
            done_d  = 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        go_off  = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
        go_off  = 1'b1;
      end
    endcase
  end

  // Entry fetch; a same-cycle write to the fetched entry is forwarded.
  always_comb begin
    bypass  = wr_accept && (wr_addr == load_idx);
    f_wave  = bypass ? wr_wave  : t_wave[load_idx];
    f_freq  = bypass ? wr_freq  : t_freq[load_idx];
    f_amp   = bypass ? wr_amp   : t_amp[load_idx];
    f_phase = bypass ? wr_phase : t_phase[load_idx];
    f_dwell = bypass ? wr_dwell : t_dwell[load_idx];
`ifdef AWG_SEQ_SWEEP_EN
    f_finc  = bypass ? wr_finc  : t_finc[load_idx];
`endif
  end

  // Table storage: cleared on reset, written only when the write is accepted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        t_wave[i]  <= '0;
        t_freq[i]  <= '0;
        t_amp[i]   <= '0;
        t_phase[i] <= '0;
        t_dwell[i] <= '0;
        t_last[i]  <= 1'b0;
`ifdef AWG_SEQ_SWEEP_EN
        t_finc[i]  <= '0;
`endif
      end
    end else if (wr_accept) begin
      t_wave[wr_addr]  <= wr_wave;
      t_freq[wr_addr]  <= wr_freq;
      t_amp[wr_addr]   <= wr_amp;
      t_phase[wr_addr] <= wr_phase;
      t_dwell[wr_addr] <= wr_dwell;
      t_last[wr_addr]  <= wr_last;
`ifdef AWG_SEQ_SWEEP_EN
      t_finc[wr_addr]  <= wr_finc;
`endif
    end
  end

  // FSM state, dwell counter and registered generator outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      loop_q      <= 1'b0;
      cnt_q       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      step_strobe <= 1'b0;
      wr_err      <= 1'b0;
      step_idx    <= '0;
      state       <= 3'd7;
      state_freq  <= '0;
      state_amp   <= '0;
      state_phase <= '0;
`ifdef AWG_SEQ_SWEEP_EN
      finc_q      <= '0;
      sc_q        <= '0;
`endif
    end else begin
      state_q     <= state_d;
      busy        <= (state_d == S_RUN);
      done        <= done_d;
      step_strobe <= load;
      wr_err      <= wr_en && (state_q != S_IDLE);
      if ((state_q == S_IDLE) && start && !stop) loop_q <= loop;
      if (load) begin
        step_idx    <= load_idx;
        state       <= f_wave;
        state_freq  <= f_freq;
        state_amp   <= f_amp;
        state_phase <= f_phase;
        cnt_q       <= (f_dwell == '0) ? '0 : f_dwell - DWELL_W'(1);
`ifdef AWG_SEQ_SWEEP_EN
        finc_q      <= f_finc;
        sc_q        <= SC_INIT;
`endif
      end else if (go_off) begin
        step_idx    <= '0;
        state       <= 3'd7;
        state_freq  <= '0;
        state_amp   <= '0;
        state_phase <= '0;
        cnt_q       <= '0;
      end else if (state_q == S_RUN) begin
        cnt_q <= cnt_q - DWELL_W'(1);
`ifdef AWG_SEQ_SWEEP_EN
        if (sc_q == SC_W'(SWEEP_DIV - 1)) begin
          sc_q       <= '0;
          state_freq <= fsum[12] ? 12'hFFF : fsum[11:0];
        end else begin
          sc_q <= sc_q + SC_W'(1);
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_awg_seq_ctrl.sv
// Bench for awg_seq_ctrl: a table model predicts the per-cycle output trace of
// each playback; one compare process checks every queued cycle, and a few
// literal checks pin strobe/done timing.
`timescale 1ns/1ps
module tb_awg_seq_ctrl;

  localparam int DEPTH   = 8;
  localparam int DWELL_W = 24;
  localparam int AW      = 3;
`ifdef AWG_SEQ_SWEEP_EN
  localparam int SWEEP_DIV = 1024;
`endif
  localparam int W = 30 + AW;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic               wr_en = 1'b0;
  logic [AW-1:0]      wr_addr = '0;
  logic [2:0]         wr_wave = '0;
  logic [11:0]        wr_freq = '0;
  logic [2:0]         wr_amp = '0;
  logic [7:0]         wr_phase = '0;
  logic [DWELL_W-1:0] wr_dwell = '0;
  logic               wr_last = 1'b0;
`ifdef AWG_SEQ_SWEEP_EN
  logic [7:0]         wr_finc = '0;
`endif
  logic               start = 1'b0;
  logic               stop = 1'b0;
  logic               loop = 1'b0;
  logic               wr_err, busy, done, step_strobe;
  logic [AW-1:0]      step_idx;
  logic [2:0]         state;
  logic [11:0]        state_freq;
  logic [2:0]         state_amp;
  logic [7:0]         state_phase;

  awg_seq_ctrl #(
    .DEPTH(DEPTH),
    .DWELL_W(DWELL_W)
`ifdef AWG_SEQ_SWEEP_EN
    , .SWEEP_DIV(SWEEP_DIV)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_wave(wr_wave), .wr_freq(wr_freq),
    .wr_amp(wr_amp), .wr_phase(wr_phase), .wr_dwell(wr_dwell), .wr_last(wr_last),
`ifdef AWG_SEQ_SWEEP_EN
    .wr_finc(wr_finc),
`endif
    .start(start), .stop(stop), .loop(loop),
    .wr_err(wr_err), .busy(busy), .done(done), .step_strobe(step_strobe),
    .step_idx(step_idx), .state(state), .state_freq(state_freq),
    .state_amp(state_amp), .state_phase(state_phase)
  );

  // model table
  int m_wave[DEPTH], m_freq[DEPTH], m_amp[DEPTH], m_phase[DEPTH];
  int m_dwell[DEPTH], m_finc[DEPTH];
  bit m_last[DEPTH];

  // scoreboard
  logic [W-1:0] exp_q[$];
  logic [W-1:0] e_v, got_v;
  int           strobe_log[$];
  int           done_log[$];
  int           cyc_abs = 0;
  int           t0 = 0, s0 = 0, d0 = 0;
  int           errors = 0;
  int           checks = 0;

  function automatic logic [W-1:0] pk(input bit werr, input bit bsy, input bit dn,
                                      input bit stb, input int idx, input int wave,
                                      input int freq, input int amp, input int phase);
    logic [AW-1:0] i_v;
    logic [2:0]    w_v;
    logic [11:0]   f_v;
    logic [2:0]    a_v;
    logic [7:0]    p_v;
    i_v = AW'(idx); w_v = 3'(wave); f_v = 12'(freq); a_v = 3'(amp); p_v = 8'(phase);
    return {werr, bsy, dn, stb, i_v, w_v, f_v, a_v, p_v};
  endfunction

  function automatic logic [W-1:0] idle_v();
    return pk(1'b0, 1'b0, 1'b0, 1'b0, 0, 7, 0, 0, 0);
  endfunction

  function automatic int model_freq(input int idx, input int k);
    int fq;
    fq = m_freq[idx];
`ifdef AWG_SEQ_SWEEP_EN
    fq = m_freq[idx] + m_finc[idx] * ((k + 1) / SWEEP_DIV);
    if (fq > 4095) fq = 4095;
`endif
    return fq;
  endfunction

  // Expected trace of a playback, truncated after max_cyc running cycles.
  task automatic build_trace(input bit lp, input int max_cyc);
    int n, idx, d;
    n = 0;
    idx = 0;
    forever begin
      d = (m_dwell[idx] == 0) ? 1 : m_dwell[idx];
      for (int k = 0; k < d; k++) begin
        if (n == max_cyc) begin
          exp_q.push_back(idle_v());
          exp_q.push_back(idle_v());
          return;
        end
        exp_q.push_back(pk(1'b0, 1'b1, 1'b0, k == 0, idx, m_wave[idx],
                           model_freq(idx, k), m_amp[idx], m_phase[idx]));
        n++;
      end
      if (!m_last[idx] && idx < DEPTH - 1) idx++;
      else if (lp) idx = 0;
      else begin
        exp_q.push_back(pk(1'b0, 1'b0, 1'b1, 1'b0, 0, 7, 0, 0, 0));
        exp_q.push_back(idle_v());
        exp_q.push_back(idle_v());
        return;
      end
    end
  endtask

  // compare process: one check per queued cycle, plus strobe/done logging
  always @(posedge clk) begin
    #1;
    cyc_abs++;
    if (exp_q.size() > 0) begin
      e_v   = exp_q.pop_front();
      got_v = {wr_err, busy, done, step_strobe, step_idx, state, state_freq,
               state_amp, state_phase};
      checks++;
      if (got_v !== e_v) begin
        errors++;
        $display("FAIL outputs cyc=%0d got=%h exp=%h (wr_err,busy,done,stb,idx,wave,freq,amp,ph)",
                 cyc_abs, got_v, e_v);
      end
    end
    if (step_strobe === 1'b1) strobe_log.push_back(cyc_abs);
    if (done === 1'b1) done_log.push_back(cyc_abs);
  end

  task automatic check_lit(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  function automatic int strobe_rel(input int i);
    if (s0 + i < strobe_log.size()) return strobe_log[s0 + i] - t0;
    return -1;
  endfunction

  function automatic int done_rel(input int i);
    if (d0 + i < done_log.size()) return done_log[d0 + i] - t0;
    return -1;
  endfunction

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    #2;
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain timeout remaining=%0d", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  // driver tasks
  task automatic wr_entry(input int a, input int wave, input int freq, input int amp,
                          input int phase, input int dwell, input bit last, input int finc);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = AW'(a); wr_wave = 3'(wave); wr_freq = 12'(freq);
    wr_amp = 3'(amp); wr_phase = 8'(phase); wr_dwell = DWELL_W'(dwell); wr_last = last;
`ifdef AWG_SEQ_SWEEP_EN
    wr_finc = 8'(finc);
`endif
    m_wave[a] = wave; m_freq[a] = freq; m_amp[a] = amp; m_phase[a] = phase;
    m_dwell[a] = dwell; m_last[a] = last; m_finc[a] = finc;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Pulse start; returns at the negedge inside playback cycle 1.
  task automatic kick(input bit lp, input int max_cyc, input int err_at, input bit with_wr);
    logic [W-1:0] tmp;
    @(negedge clk);
    build_trace(lp, max_cyc);
    if (err_at >= 0) begin
      tmp = exp_q[err_at];
      tmp[W-1] = 1'b1;
      exp_q[err_at] = tmp;
    end
    s0 = strobe_log.size(); d0 = done_log.size(); t0 = cyc_abs;
    start = 1'b1; loop = lp; wr_en = with_wr;
    @(negedge clk);
    start = 1'b0; loop = 1'b0; wr_en = 1'b0;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      m_wave[i] = 0; m_freq[i] = 0; m_amp[i] = 0; m_phase[i] = 0;
      m_dwell[i] = 0; m_finc[i] = 0; m_last[i] = 1'b0;
    end

    // reset outputs: off values for 10 idle cycles
    repeat (3) @(negedge clk);
    for (int i = 0; i < 10; i++) exp_q.push_back(idle_v());
    rst_n = 1'b1;
    drain(50);

    // three-step playback, dwell 3/1/0, last on entry 2
    wr_entry(0, 3, 100, 5, 16, 3, 1'b0, 0);
    wr_entry(1, 1, 2000, 2, 200, 1, 1'b0, 0);
    wr_entry(2, 2, 4095, 7, 255, 0, 1'b1, 0);
    kick(1'b0, 100000, -1, 1'b0);
    drain(100);
    check_lit("3step_strobe_count", strobe_log.size() - s0, 3);
    check_lit("3step_strobe0", strobe_rel(0), 1);
    check_lit("3step_strobe1", strobe_rel(1), 4);
    check_lit("3step_strobe2", strobe_rel(2), 5);
    check_lit("3step_done", done_rel(0), 6);

    // loop, then stop mid-step at cycle 13
    kick(1'b1, 12, -1, 1'b0);
    repeat (11) @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    drain(100);
    check_lit("loop_strobe_count", strobe_log.size() - s0, 7);
    check_lit("loop_wrap_strobe", strobe_rel(3), 6);
    check_lit("loop_second_wrap", strobe_rel(6), 11);
    check_lit("loop_no_done", done_log.size() - d0, 0);

    // full table, dwell 2, no last flags
    for (int i = 0; i < DEPTH; i++) wr_entry(i, i % 5, i * 300 + 7, i % 8, i * 31, 2, 1'b0, 0);
    kick(1'b0, 100000, -1, 1'b0);
    drain(100);
    check_lit("full_strobe_count", strobe_log.size() - s0, DEPTH);
    check_lit("full_done", done_rel(0), 2 * DEPTH + 1);

    // rejected write during RUN, then replay of the unchanged table
    kick(1'b0, 100000, 3, 1'b0);
    repeat (2) @(negedge clk);
    wr_en = 1'b1; wr_addr = '0; wr_wave = 3'd4; wr_freq = 12'd4000; wr_amp = 3'd1;
    wr_phase = 8'd77; wr_dwell = DWELL_W'(9); wr_last = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
    drain(100);
    kick(1'b0, 100000, -1, 1'b0);
    drain(100);
    check_lit("replay_done", done_rel(0), 2 * DEPTH + 1);

    // start together with stop in IDLE: stays idle
    @(negedge clk);
    for (int i = 0; i < 4; i++) exp_q.push_back(idle_v());
    s0 = strobe_log.size();
    start = 1'b1; stop = 1'b1; loop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0; loop = 1'b0;
    drain(50);
    check_lit("startstop_no_strobe", strobe_log.size() - s0, 0);

    // write to entry 0 in the same cycle as start: new data is played
    wr_addr = '0; wr_wave = 3'd4; wr_freq = 12'd1234; wr_amp = 3'd3; wr_phase = 8'd99;
    wr_dwell = DWELL_W'(2); wr_last = 1'b0;
`ifdef AWG_SEQ_SWEEP_EN
    wr_finc = 8'd0;
`endif
    m_wave[0] = 4; m_freq[0] = 1234; m_amp[0] = 3; m_phase[0] = 99;
    m_dwell[0] = 2; m_last[0] = 1'b0; m_finc[0] = 0;
    kick(1'b0, 100000, -1, 1'b1);
    drain(100);

    // reset mid-playback clears the table; replay shows all-zero entries
    kick(1'b1, 4, -1, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      m_wave[i] = 0; m_freq[i] = 0; m_amp[i] = 0; m_phase[i] = 0;
      m_dwell[i] = 0; m_finc[i] = 0; m_last[i] = 1'b0;
    end
    @(negedge clk);
    rst_n = 1'b1;
    drain(100);
    kick(1'b0, 100000, -1, 1'b0);
    drain(100);
    check_lit("cleared_done", done_rel(0), DEPTH + 1);

`ifdef AWG_SEQ_SWEEP_EN
    // sweep: 4090 + 4 per 1024 cycles, saturating at 4095
    wr_entry(0, 3, 4090, 7, 0, 5000, 1'b1, 4);
    kick(1'b0, 100000, -1, 1'b0);
    repeat (1022) @(negedge clk);
    check_lit("sweep_c1023", state_freq, 4090);
    @(negedge clk);
    check_lit("sweep_c1024", state_freq, 4094);
    repeat (1024) @(negedge clk);
    check_lit("sweep_c2048", state_freq, 4095);
    repeat (1024) @(negedge clk);
    check_lit("sweep_c3072", state_freq, 4095);
    drain(8000);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
